mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1, MMU read latency in cycles from the read strobe to valid iMemData; legal range 1..15.
REQ-002 iClk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 iRst  input  1  reset; synchronous and active-high.
REQ-004 iReqRead  input  2  per-requester read request; bit 0 is the processor and bit 1 is the loader/debug port.
REQ-005 iReqWrite  input  2  per-requester write request.
REQ-006 iReqAddr  input  64  packed addresses; requester n uses bits [32n+31:32n].
REQ-007 iReqData  input  64  packed write data, packed the same way.
REQ-008 oReqData  output  32  read data returned to the granted requester.
REQ-009 oReqRdy  output  2  one-cycle completion pulse per requester.
REQ-010 oMemRead  output  1  read strobe to the MMU.
REQ-011 oMemWrite  output  1  write strobe to the MMU.
REQ-012 oMemAddr  output  32  MMU address.
REQ-013 oMemData  output  32  MMU write data.
REQ-014 iMemData  input  32  MMU read data.
REQ-015 oBusy  output  1  high whenever state is not IDLE.
REQ-016 oOwner  output  1  index of the current or most recent grant.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS, WAIT and RESP, and all outputs SHALL be registered.
REQ-018 IDLE: a requester is pending if its read OR write bit is high. With no pending requester the FSM SHALL stay in IDLE. Otherwise it SHALL pick a winner, latch that requester's address, data and op into oMemAddr/oMemData, set oOwner, and go to ACCESS.
REQ-019 If a requester asserts read and write together, the transaction SHALL be treated as a write.
REQ-020 ACCESS SHALL last exactly 1 cycle and assert exactly one of oMemRead/oMemWrite. Next state SHALL be WAIT for a read and RESP for a write.
REQ-021 WAIT SHALL last exactly MEM_LAT cycles, counted by a 4-bit down-counter. iMemData SHALL be captured into oReqData on the edge ending the final WAIT cycle; the FSM then goes to RESP.
REQ-022 RESP SHALL last 1 cycle with oReqRdy[oOwner]=1 and the other bit 0, then go to IDLE.
REQ-023 Latency, counted from the IDLE cycle in which a request is seen as cycle 0: write Rdy SHALL occur in cycle 2; read Rdy SHALL occur in cycle 2+MEM_LAT.
REQ-024 oMemRead and oMemWrite SHALL be low in every state except ACCESS.
REQ-025 oMemAddr and oMemData SHALL hold their latched values until the next grant.
REQ-026 Requests SHALL be sampled only in IDLE. Request changes during ACCESS, WAIT or RESP SHALL be ignored.
REQ-027 A requester SHALL deassert its request on the edge ending its RESP cycle. A request still high in the following IDLE cycle SHALL be treated as a new transaction.
REQ-028 oReqData SHALL retain the last read value through writes and idle periods; it is not cleared after a read.
REQ-029 Back-to-back transactions SHALL have a minimum gap of 1 IDLE cycle between RESP and the next ACCESS.
REQ-030 Starvation freedom is guaranteed only when ARB_ROUND_ROBIN_EN is defined.

Reset
REQ-031 While iRst=1 at an edge, the arbiter SHALL set state=IDLE and clear the WAIT counter.
REQ-032 While iRst=1 at an edge, it SHALL clear oMemRead, oMemWrite, oMemAddr, oMemData, oReqData, oReqRdy, oBusy and oOwner to 0.
REQ-033 While iRst=1 at an edge, the round-robin last-grant pointer SHALL be set to 1.
REQ-034 Reset in any non-IDLE state SHALL abort the transaction with no oReqRdy pulse; a strobe already issued to the MMU is not retracted.
REQ-035 If iRst and a request are both high in the same cycle, reset SHALL win and no grant SHALL be made.

Configuration
REQ-036 With ARB_ROUND_ROBIN_EN defined: when both requesters are pending in IDLE, the grant SHALL go to the requester not granted last; a lone requester SHALL always win. The pointer SHALL update on every grant, and after reset requester 0 SHALL win the first contention.
REQ-037 With ARB_ROUND_ROBIN_EN undefined: fixed priority SHALL apply, requester 0 SHALL always win contention, and no pointer register SHALL exist.

Verification
REQ-038 MEM_LAT=1; requester 0 reads addr 0x10 holding 0xDEADBEEF -> oMemRead high in cycle 1 only, oReqRdy=01 in cycle 3, oReqData=0xDEADBEEF.
REQ-039 Requester 1 writes 0xCAFEF00D to 0x20 -> oMemWrite in cycle 1 with oMemAddr=0x20 and oMemData=0xCAFEF00D, oReqRdy=10 in cycle 2; a following read of 0x20 returns 0xCAFEF00D.
REQ-040 Both requesters read continuously with ARB_ROUND_ROBIN_EN defined -> grants alternate 0,1,0,1. With it undefined -> every grant goes to requester 0.
REQ-041 MEM_LAT=3 read -> WAIT lasts 3 cycles and oReqRdy occurs in cycle 5.
REQ-042 iRst pulsed during WAIT -> no oReqRdy, all outputs 0 next cycle, and the next request is granted normally from IDLE.
REQ-043 Requester sets iReqRead=1 and iReqWrite=1 together -> only oMemWrite asserts and oReqData is unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter in front of a fixed-latency MMU port.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; the default build uses fixed priority (requester 0 wins).
module mem_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic [1:0]  iReqRead,
  input  logic [1:0]  iReqWrite,
  input  logic [63:0] iReqAddr,
  input  logic [63:0] iReqData,
  output logic [31:0] oReqData,
  output logic [1:0]  oReqRdy,
  output logic        oMemRead,
  output logic        oMemWrite,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  input  logic [31:0] iMemData,
  output logic        oBusy,
  output logic        oOwner
);

  // state  | meaning
  // IDLE   | sample requests, grant a winner
  // ACCESS | one-cycle read or write strobe to the MMU
  // WAIT   | MEM_LAT cycles for read data; data captured on the last one
  // RESP   | one-cycle completion pulse to the owner
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic        r_is_write;
  logic [1:0]  w_pending;
  logic        w_grant;
  logic        w_win;
  logic        w_win_write;
  logic [5:0]  w_win_base;

  logic [31:0] r_req_data;
  logic [1:0]  r_req_rdy;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_data;
  logic        r_busy;
  logic        r_owner;

  assign w_pending = iReqRead | iReqWrite;
  assign w_grant   = (r_state == S_IDLE) && (|w_pending);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last;

  always_comb begin
    w_win = w_pending[1];
    if (w_pending == 2'b11) w_win = ~r_last;
  end

  always_ff @(posedge iClk) begin
    if (iRst)         r_last <= 1'b1;
    else if (w_grant) r_last <= w_win;
  end
`else
  assign w_win = ~w_pending[0];
`endif

  // Read and write together resolves to a write.
  assign w_win_write = iReqWrite[w_win];
  assign w_win_base  = {w_win, 5'd0};

  always_ff @(posedge iClk) begin
    if (iRst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (|w_pending) w_state_nxt = S_ACCESS;
      S_ACCESS: w_state_nxt = r_is_write ? S_RESP : S_WAIT;
      S_WAIT:   if (r_wait_cnt == 4'd0) w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_wait_cnt  <= 4'd0;
      r_is_write  <= 1'b0;
      r_req_data  <= 32'd0;
      r_req_rdy   <= 2'b00;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_data  <= 32'd0;
      r_busy      <= 1'b0;
      r_owner     <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != S_IDLE);
      r_mem_read  <= w_grant && !w_win_write;
      r_mem_write <= w_grant && w_win_write;
      r_req_rdy   <= 2'b00;
      if (w_grant) begin
        r_owner    <= w_win;
        r_is_write <= w_win_write;
        r_mem_addr <= iReqAddr[w_win_base +: 32];
        r_mem_data <= iReqData[w_win_base +: 32];
      end
      if (r_state == S_ACCESS) begin
        r_wait_cnt <= 4'(MEM_LAT - 1);
      end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
      if (r_state == S_WAIT && r_wait_cnt == 4'd0) r_req_data <= iMemData;
      if (w_state_nxt == S_RESP) r_req_rdy <= r_owner ? 2'b10 : 2'b01;
    end
  end

  assign oReqData  = r_req_data;
  assign oReqRdy   = r_req_rdy;
  assign oMemRead  = r_mem_read;
  assign oMemWrite = r_mem_write;
  assign oMemAddr  = r_mem_addr;
  assign oMemData  = r_mem_data;
  assign oBusy     = r_busy;
  assign oOwner    = r_owner;

endmodule
